// File: rtl/chx_pkg.sv
// Shared types for the CHX receive path: buffer entry layout and framing FSM states.
package chx_pkg;
    localparam int CHX_DATA_W = 8;
    localparam int CHX_ID_W   = 3;

    typedef struct packed {
        logic [CHX_ID_W-1:0]   id;
        logic                  qos;
        logic                  sop;
        logic                  eop;
        logic [CHX_DATA_W-1:0] data;
    } chx_entry_t;

    typedef enum logic [1:0] {IDLE, RECV, DROP} chx_state_e;
endpackage

// File: rtl/chx_pkt_buf.sv
// Store-and-forward packet RAM: speculative/committed write pointers with single-cycle
// commit and rewind, show-ahead registered read that exposes committed data only.
module chx_pkt_buf
    import chx_pkg::*;
#(
    parameter int BUF_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_wr_en,
    input  chx_entry_t                    i_wr_data,
    input  logic                          i_commit,
    input  logic                          i_rewind,
    input  logic                          i_rd_rdy,
    output chx_entry_t                    o_rd_data,
    output logic                          o_rd_vld,
    output logic                          o_full_spec,
    output logic                          o_full_cmt,
    output logic [$clog2(BUF_DEPTH):0]    o_free_cnt
);
    localparam int ADDR_W = $clog2(BUF_DEPTH);
    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(BUF_DEPTH);

    chx_entry_t      r_mem [BUF_DEPTH];
    chx_entry_t      r_dout;
    logic            r_vld;
    logic [ADDR_W:0] r_wr_spec, r_wr_cmt, r_rd;
    logic [ADDR_W:0] w_base, w_spec_nxt, w_rd_nxt, w_used_spec, w_used_cmt;

    // A rewind and a new write may coincide: the write lands at the committed pointer.
    assign w_base      = i_rewind ? r_wr_cmt : r_wr_spec;
    assign w_spec_nxt  = w_base + (ADDR_W+1)'(i_wr_en);
    assign w_rd_nxt    = r_rd + (ADDR_W+1)'(r_vld & i_rd_rdy);
    assign w_used_spec = r_wr_spec - r_rd;
    assign w_used_cmt  = r_wr_cmt - r_rd;

    assign o_full_spec = (w_used_spec == DEPTH_P);
    assign o_full_cmt  = (w_used_cmt == DEPTH_P);
    assign o_free_cnt  = DEPTH_P - w_used_spec;
    assign o_rd_data   = r_dout;
    assign o_rd_vld    = r_vld;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[w_base[ADDR_W-1:0]] <= i_wr_data;
    end

    // Comparing against the pre-update commit pointer gives the extra cycle that lets
    // the RAM write settle before the byte is read back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_spec <= '0;
            r_wr_cmt  <= '0;
            r_rd      <= '0;
            r_vld     <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_wr_spec <= w_spec_nxt;
            if (i_commit) r_wr_cmt <= w_spec_nxt;
            r_rd      <= w_rd_nxt;
            r_vld     <= (w_rd_nxt != r_wr_cmt);
            r_dout    <= r_mem[w_rd_nxt[ADDR_W-1:0]];
        end
    end
endmodule

// File: rtl/chx_in_ctrl.sv
// CHX receive controller: framing FSM, length/id checks, qos/id latch and status pulses
// in front of the store-and-forward packet buffer.
module chx_in_ctrl
    import chx_pkg::*;
#(
    parameter int BUF_DEPTH    = 64,
    parameter int MAX_PKT_LEN  = 32,
    parameter int AFULL_THRESH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CHX_DATA_W-1:0]       chx_data_in,
    input  logic                        chx_sop_in,
    input  logic                        chx_eop_in,
    input  logic                        chx_qos_in,
    input  logic                        chx_data_vld,
    input  logic [CHX_ID_W-1:0]         chx_id_in,
    output logic [CHX_DATA_W-1:0]       pkt_data_out,
    output logic                        pkt_sop_out,
    output logic                        pkt_eop_out,
    output logic                        pkt_qos_out,
    output logic [CHX_ID_W-1:0]         pkt_id_out,
    output logic                        pkt_vld_out,
    input  logic                        pkt_rdy_in,
    output logic                        rx_afull,
    output logic [$clog2(BUF_DEPTH):0]  rx_free_cnt,
    output logic                        rx_pkt_incr,
    output logic                        rx_err_incr
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

    chx_state_e          r_state, w_nxt_state;
    logic [LEN_W-1:0]    r_len, w_len_nxt;
    logic [CHX_ID_W-1:0] r_id;
    logic                r_qos, r_pkt_incr, r_err_incr;
    logic                w_wr_en, w_commit, w_rewind, w_err, w_pkt, w_start, w_latch;
    logic                w_full_spec, w_full_cmt;
    chx_entry_t          w_wr_data, w_rd_data;

    assign w_wr_data.id   = w_latch ? chx_id_in : r_id;
    assign w_wr_data.qos  = w_latch ? chx_qos_in : r_qos;
    assign w_wr_data.sop  = chx_sop_in;
    assign w_wr_data.eop  = chx_eop_in;
    assign w_wr_data.data = chx_data_in;

    always_comb begin
        w_nxt_state = r_state;
        w_len_nxt   = r_len;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        w_rewind    = 1'b0;
        w_err       = 1'b0;
        w_pkt       = 1'b0;
        w_start     = 1'b0;
        w_latch     = 1'b0;
        if (chx_data_vld) begin
            case (r_state)
                IDLE: begin
                    if (chx_sop_in) w_start = 1'b1;
                    else            w_err   = 1'b1;
                end
                RECV: begin
                    if (chx_sop_in) begin
                        w_rewind = 1'b1;
                        w_err    = 1'b1;
                        w_start  = 1'b1;
                    end else if (chx_id_in != r_id || w_full_spec ||
                                 r_len == LEN_W'(MAX_PKT_LEN)) begin
                        w_rewind    = 1'b1;
                        w_err       = 1'b1;
                        w_nxt_state = chx_eop_in ? IDLE : DROP;
                    end else begin
                        w_wr_en = 1'b1;
                        if (chx_eop_in) begin
                            w_commit    = 1'b1;
                            w_pkt       = 1'b1;
                            w_nxt_state = IDLE;
                        end else begin
                            w_len_nxt = r_len + 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (chx_sop_in)      w_start     = 1'b1;
                    else if (chx_eop_in) w_nxt_state = IDLE;
                end
                default: w_nxt_state = IDLE;
            endcase
            // Outside RECV (or after a rewind) the speculative and committed pointers
            // coincide, so the committed fullness is the right check for a packet start.
            if (w_start) begin
                if (w_full_cmt) begin
                    w_err       = 1'b1;
                    w_nxt_state = chx_eop_in ? IDLE : DROP;
                end else begin
                    w_wr_en   = 1'b1;
                    w_latch   = 1'b1;
                    w_len_nxt = LEN_W'(1);
                    if (chx_eop_in) begin
                        w_commit    = 1'b1;
                        w_pkt       = 1'b1;
                        w_nxt_state = IDLE;
                    end else begin
                        w_nxt_state = RECV;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_id       <= '0;
            r_qos      <= 1'b0;
            r_pkt_incr <= 1'b0;
            r_err_incr <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_len      <= w_len_nxt;
            r_pkt_incr <= w_pkt;
            r_err_incr <= w_err;
            if (w_latch) begin
                r_id  <= chx_id_in;
                r_qos <= chx_qos_in;
            end
        end
    end

    chx_pkt_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (w_wr_en),
        .i_wr_data   (w_wr_data),
        .i_commit    (w_commit),
        .i_rewind    (w_rewind),
        .i_rd_rdy    (pkt_rdy_in),
        .o_rd_data   (w_rd_data),
        .o_rd_vld    (pkt_vld_out),
        .o_full_spec (w_full_spec),
        .o_full_cmt  (w_full_cmt),
        .o_free_cnt  (rx_free_cnt)
    );

    assign pkt_data_out = w_rd_data.data;
    assign pkt_sop_out  = w_rd_data.sop;
    assign pkt_eop_out  = w_rd_data.eop;
    assign pkt_qos_out  = w_rd_data.qos;
    assign pkt_id_out   = w_rd_data.id;
    assign rx_afull     = (rx_free_cnt < CNT_W'(AFULL_THRESH));
    assign rx_pkt_incr  = r_pkt_incr;
    assign rx_err_incr  = r_err_incr;
endmodule

// File: tb/tb_chx_in_ctrl.sv
// Scoreboard bench for chx_in_ctrl: framing, drop/commit, back-pressure and reset cases.
module tb_chx_in_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] chx_data_in;
    logic       chx_sop_in, chx_eop_in, chx_qos_in, chx_data_vld;
    logic [2:0] chx_id_in;
    logic [7:0] pkt_data_out;
    logic       pkt_sop_out, pkt_eop_out, pkt_qos_out, pkt_vld_out, pkt_rdy_in;
    logic [2:0] pkt_id_out;
    logic       rx_afull, rx_pkt_incr, rx_err_incr;
    logic [6:0] rx_free_cnt;

    logic [13:0] sb[$];
    int n_tests = 0, n_fail = 0, cnt_pkt = 0, cnt_err = 0;
    int p0, e0;

    always #5 clk = ~clk;

    chx_in_ctrl #(.BUF_DEPTH(64), .MAX_PKT_LEN(32), .AFULL_THRESH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .chx_data_in(chx_data_in), .chx_sop_in(chx_sop_in), .chx_eop_in(chx_eop_in),
        .chx_qos_in(chx_qos_in), .chx_data_vld(chx_data_vld), .chx_id_in(chx_id_in),
        .pkt_data_out(pkt_data_out), .pkt_sop_out(pkt_sop_out), .pkt_eop_out(pkt_eop_out),
        .pkt_qos_out(pkt_qos_out), .pkt_id_out(pkt_id_out), .pkt_vld_out(pkt_vld_out),
        .pkt_rdy_in(pkt_rdy_in), .rx_afull(rx_afull), .rx_free_cnt(rx_free_cnt),
        .rx_pkt_incr(rx_pkt_incr), .rx_err_incr(rx_err_incr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every vld&rdy transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_pkt_incr) cnt_pkt++;
            if (rx_err_incr) cnt_err++;
            if (pkt_vld_out && pkt_rdy_in) begin
                chk("sb_avail", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0)
                    chk("pkt_byte", {pkt_id_out, pkt_qos_out, pkt_sop_out, pkt_eop_out,
                                     pkt_data_out}, sb.pop_front());
            end
        end
    end

    task automatic drv(input logic [7:0] d, input logic s, input logic e,
                       input logic q, input logic [2:0] id);
        @(posedge clk); #1;
        chx_data_in = d; chx_sop_in = s; chx_eop_in = e;
        chx_qos_in = q; chx_id_in = id; chx_data_vld = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chx_data_vld = 1'b0; chx_sop_in = 1'b0; chx_eop_in = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic s, input logic e,
                        input logic q, input logic [2:0] id);
        sb.push_back({id, q, s, e, d});
    endtask

    task automatic send_pkt(input int len, input logic [2:0] id, input logic q,
                            input logic [7:0] base, input bit ok);
        for (int i = 0; i < len; i++) begin
            logic s, e;
            s = (i == 0);
            e = (i == len - 1);
            if (ok) push(base + 8'(i), s, e, q, id);
            drv(base + 8'(i), s, e, q, id);
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic reset_chk(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        chx_data_vld = 1'b0; chx_sop_in = 1'b0; chx_eop_in = 1'b0;
        sb.delete();
        @(negedge clk);
        chk({tag, "_vld"},  pkt_vld_out, 0);
        chk({tag, "_free"}, rx_free_cnt, 64);
        chk({tag, "_afull"}, rx_afull, 0);
        chk({tag, "_pulses"}, {rx_pkt_incr, rx_err_incr}, 0);
        chk({tag, "_data"}, {pkt_id_out, pkt_qos_out, pkt_sop_out, pkt_eop_out, pkt_data_out}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pkt_rdy_in = 1'b1;
        chx_data_in = '0; chx_sop_in = 0; chx_eop_in = 0; chx_qos_in = 0;
        chx_data_vld = 0; chx_id_in = '0;
        reset_chk("rst");

        // 1: 4-byte packet, latency and framing
        p0 = cnt_pkt; e0 = cnt_err;
        send_pkt(4, 3'd3, 1'b1, 8'h10, 1);
        idle(1);
        @(negedge clk); chk("t1_lat_early", pkt_vld_out, 0);
        @(negedge clk); chk("t1_lat_vld", pkt_vld_out, 1);
        chk("t1_first", pkt_data_out, 8'h10);
        drain("t1_drain");
        chk("t1_pkt", cnt_pkt - p0, 1);
        chk("t1_err", cnt_err - e0, 0);

        // 2: single-byte packet
        p0 = cnt_pkt;
        send_pkt(1, 3'd5, 1'b0, 8'hA5, 1);
        idle(3);
        drain("t2_drain");
        chk("t2_pkt", cnt_pkt - p0, 1);

        // 3: missing eop, restart on new sop
        p0 = cnt_pkt; e0 = cnt_err;
        drv(8'h01, 1, 0, 0, 3'd2);
        drv(8'h02, 0, 0, 0, 3'd2);
        push(8'hB0, 1, 0, 0, 3'd2); drv(8'hB0, 1, 0, 0, 3'd2);
        push(8'hB1, 0, 1, 0, 3'd2); drv(8'hB1, 0, 1, 0, 3'd2);
        idle(3);
        drain("t3_drain");
        chk("t3_err", cnt_err - e0, 1);
        chk("t3_pkt", cnt_pkt - p0, 1);

        // 4: over-length packet dropped, next one intact
        p0 = cnt_pkt; e0 = cnt_err;
        send_pkt(40, 3'd1, 1'b0, 8'h00, 0);
        idle(2);
        chk("t4_err", cnt_err - e0, 1);
        chk("t4_pkt_none", cnt_pkt - p0, 0);
        send_pkt(4, 3'd4, 1'b1, 8'h40, 1);
        idle(3);
        drain("t4_drain");
        idle(2);
        @(negedge clk); chk("t4_free", rx_free_cnt, 64);
        chk("t4_pkt", cnt_pkt - p0, 1);

        // 5: overflow with downstream stalled
        pkt_rdy_in = 1'b0;
        p0 = cnt_pkt; e0 = cnt_err;
        send_pkt(16, 3'd0, 1'b0, 8'h00, 1);
        send_pkt(16, 3'd1, 1'b1, 8'h20, 1);
        idle(1);
        @(negedge clk);
        chk("t5_free32", rx_free_cnt, 32);
        chk("t5_afull0", rx_afull, 0);
        send_pkt(16, 3'd2, 1'b0, 8'h40, 1);
        idle(1);
        @(negedge clk);
        chk("t5_free16", rx_free_cnt, 16);
        chk("t5_afull1", rx_afull, 1);
        send_pkt(16, 3'd3, 1'b1, 8'h60, 1);
        send_pkt(16, 3'd4, 1'b0, 8'h80, 0);
        idle(3);
        @(negedge clk);
        chk("t5_free0", rx_free_cnt, 0);
        chk("t5_err", cnt_err - e0, 1);
        chk("t5_pkt", cnt_pkt - p0, 4);
        @(posedge clk); #1; pkt_rdy_in = 1'b1;
        drain("t5_drain");
        idle(2);
        @(negedge clk); chk("t5_free_back", rx_free_cnt, 64);

        // 6: reset mid-RECV and mid-readout
        drv(8'hE0, 1, 0, 1, 3'd6);
        drv(8'hE1, 0, 0, 1, 3'd6);
        reset_chk("t6a");
        pkt_rdy_in = 1'b0;
        send_pkt(8, 3'd6, 1'b1, 8'hC0, 1);
        idle(3);
        @(negedge clk); chk("t6_held_vld", pkt_vld_out, 1);
        @(posedge clk); #1; pkt_rdy_in = 1'b1;
        @(posedge clk);
        reset_chk("t6b");
        p0 = cnt_pkt; e0 = cnt_err;
        send_pkt(4, 3'd7, 1'b0, 8'hD0, 1);
        idle(3);
        drain("t6_drain");
        idle(2);
        @(negedge clk); chk("t6_free", rx_free_cnt, 64);
        chk("t6_pkt", cnt_pkt - p0, 1);
        chk("t6_err", cnt_err - e0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
